// File: rtl/core_pkg.sv
// Shared core constants: datapath width, result-select encodings and access sizes.
package core_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // Low two bits of funct3 select the access size for loads and stores.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

endpackage

// File: rtl/mem_align_chk.sv
// Flags a memory access whose address is not a multiple of its access size.
module mem_align_chk
  import core_pkg::*;
(
  input  logic [1:0] size,
  input  logic [2:0] addrLow,
  input  logic       isAccess,
  output logic       misaligned
);

  logic offFault;

  always_comb begin
    offFault = 1'b0;
    case (size)
      SZ_B:    offFault = 1'b0;
      SZ_H:    offFault = addrLow[0];
      SZ_W:    offFault = |addrLow[1:0];
      SZ_D:    offFault = |addrLow;
      default: offFault = 1'b0;
    endcase
    misaligned = isAccess & offFault;
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with misaligned-access squashing and optional
// performance counters (enabled by defining EXMEM_PERF_EN).
module ex_mem_reg
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic              ValidE,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   WriteDataE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [4:0]        RdE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        funct3E,
  output logic              ValidM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [4:0]        RdM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [2:0]        funct3M,
  output logic              MisalignM,
  output logic [PERF_W-1:0] PerfInstM,
  output logic [PERF_W-1:0] PerfBubbleM
);

  logic accessE;
  logic misalignE;

  assign accessE = MemWriteE | (ResultSrcE == RES_LOAD);

  mem_align_chk uAlign (
    .size       (funct3E[1:0]),
    .addrLow    (ALUResultE[2:0]),
    .isAccess   (accessE),
    .misaligned (misalignE)
  );

  // A misaligned access stays valid so it can trap, but must not write anything.
  always_ff @(posedge clk) begin
    if (reset) begin
      ValidM     <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      funct3M    <= '0;
      MisalignM  <= 1'b0;
    end else if (FlushM) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MisalignM <= 1'b0;
    end else if (!StallM) begin
      ValidM     <= ValidE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      ResultSrcM <= ResultSrcE;
      funct3M    <= funct3E;
      MisalignM  <= ValidE & misalignE;
      RegWriteM  <= ValidE & RegWriteE & ~misalignE;
      MemWriteM  <= ValidE & MemWriteE & ~misalignE;
    end
  end

`ifdef EXMEM_PERF_EN
  localparam logic [PERF_W-1:0] PerfMax = '1;
  localparam logic [PERF_W-1:0] PerfOne = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] instCnt;
  logic [PERF_W-1:0] bubbleCnt;

  // Counters saturate; a flush counts as a bubble even while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      instCnt   <= '0;
      bubbleCnt <= '0;
    end else if (FlushM) begin
      if (bubbleCnt != PerfMax) bubbleCnt <= bubbleCnt + PerfOne;
    end else if (!StallM) begin
      if (ValidE) begin
        if (instCnt != PerfMax) instCnt <= instCnt + PerfOne;
      end else begin
        if (bubbleCnt != PerfMax) bubbleCnt <= bubbleCnt + PerfOne;
      end
    end
  end

  assign PerfInstM   = instCnt;
  assign PerfBubbleM = bubbleCnt;
`else
  assign PerfInstM   = '0;
  assign PerfBubbleM = '0;
`endif

endmodule
